// File: rtl/divider_block_24465.sv
// Restoring shift-subtract divider by the constant 24465.
// Ports: i_valid/i_ready/i_data0 in, o_valid/o_ready/o_quot/o_rem/o_exact out.
module divider_block_24465 #(
  parameter int WIDTH   = 32,
  parameter int DIVISOR = 24465,
  parameter int REM_W   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_data0,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_quot,
  output logic [REM_W-1:0] o_rem,
  output logic             o_exact
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [REM_W:0] DIV_C = (REM_W+1)'(DIVISOR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_quot;
  logic [REM_W:0]   r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic [REM_W:0]   w_t;
  logic [REM_W:0]   w_diff;
  logic             w_ge;

  // Partial remainder stays below DIVISOR, so REM_W low bits plus
  // the incoming dividend bit always fit in REM_W+1 bits.
  assign w_t    = {r_rem[REM_W-1:0], r_div[WIDTH-1]};
  assign w_ge   = (w_t >= DIV_C);
  assign w_diff = w_t - DIV_C;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (i_valid) w_next = S_RUN;
      S_RUN:  if (r_cnt == '0) w_next = S_DONE;
      S_DONE: if (o_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    i_ready = (r_state == S_IDLE);
    o_valid = (r_state == S_DONE);
    o_exact = (r_state == S_DONE) && (r_rem == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_div  <= i_data0;
            r_quot <= '0;
            r_rem  <= '0;
            r_cnt  <= CNT_W'(WIDTH-1);
          end
        end
        S_RUN: begin
          r_rem  <= w_ge ? w_diff : w_t;
          r_quot <= {r_quot[WIDTH-2:0], w_ge};
          r_div  <= r_div << 1;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_quot = r_quot;
  assign o_rem  = r_rem[REM_W-1:0];

endmodule
